// File: rtl/peridot_pfc_arbiter.sv
// peridot_pfc_arbiter
// Round-robin owner arbiter for the pin function controller. The winning
// requester's pinsel/funcsel words are written to PFC registers 2 and 3
// over an Avalon-MM master before its grant is raised. On release, the
// default words are written back before the next owner is chosen.

module peridot_pfc_arbiter #(
  parameter int          NUM_REQ          = 4,
  parameter logic [31:0] DEFAULT_PINREGS  = 32'h00000000,
  parameter logic [31:0] DEFAULT_FUNCREGS = 32'h00000000
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset_n,
  input  logic [NUM_REQ-1:0]    coe_req,
  output logic [NUM_REQ-1:0]    coe_gnt,
  input  logic [32*NUM_REQ-1:0] coe_cfg_pinsel,
  input  logic [32*NUM_REQ-1:0] coe_cfg_funcsel,
  output logic                  coe_busy,
  output logic [1:0]            avm_address,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic                  avm_waitrequest
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PIN,
    ST_WR_FUNC,
    ST_GRANT,
    ST_REL_PIN,
    ST_REL_FUNC
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          win_found;
  logic [31:0]   win_pin;
  logic [31:0]   win_func;
  logic [31:0]   pin_q;
  logic [31:0]   func_q;
  logic          owner_req;

  assign owner_req = coe_req[idx_q];

  // Round-robin scan: first active request after the last owner wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && coe_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the configuration words belonging to the scan winner
  always_comb begin
    win_pin  = '0;
    win_func = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_pin  = coe_cfg_pinsel[32*i +: 32];
        win_func = coe_cfg_funcsel[32*i +: 32];
      end
    end
  end

  // State, owner index, shadow config words and round-robin pointer
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      pin_q   <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && win_found) begin
        idx_q  <= win_idx;
        pin_q  <= win_pin;
        func_q <= win_func;
      end
      if (state_q == ST_REL_FUNC && !avm_waitrequest) begin
        ptr_q <= idx_q;
      end
    end
  end

  // Next-state: each write state advances only when the slave accepts
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (win_found) state_d = ST_WR_PIN;
      ST_WR_PIN:   if (!avm_waitrequest) state_d = ST_WR_FUNC;
      ST_WR_FUNC:  if (!avm_waitrequest) state_d = owner_req ? ST_GRANT : ST_REL_PIN;
      ST_GRANT:    if (!owner_req) state_d = ST_REL_PIN;
      ST_REL_PIN:  if (!avm_waitrequest) state_d = ST_REL_FUNC;
      ST_REL_FUNC: if (!avm_waitrequest) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so they drop with async reset
  always_comb begin
    coe_gnt       = '0;
    coe_busy      = (state_q != ST_IDLE);
    avm_write     = 1'b0;
    avm_address   = 2'd0;
    avm_writedata = 32'h0;
    case (state_q)
      ST_WR_PIN: begin
        avm_write     = 1'b1;
        avm_address   = 2'd2;
        avm_writedata = pin_q;
      end
      ST_WR_FUNC: begin
        avm_write     = 1'b1;
        avm_address   = 2'd3;
        avm_writedata = func_q;
      end
      ST_GRANT: coe_gnt[idx_q] = 1'b1;
      ST_REL_PIN: begin
        avm_write     = 1'b1;
        avm_address   = 2'd2;
        avm_writedata = DEFAULT_PINREGS;
      end
      ST_REL_FUNC: begin
        avm_write     = 1'b1;
        avm_address   = 2'd3;
        avm_writedata = DEFAULT_FUNCREGS;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_peridot_pfc_arbiter.sv
// tb_peridot_pfc_arbiter
// Self-checking bench for the PFC owner arbiter: a hand-written vector
// table for a single ownership, scripted corner-case sequences, and
// random stimulus compared against an ownership-level reference model.

module tb_peridot_pfc_arbiter;

  localparam int          N    = 4;
  localparam logic [31:0] DEFP = 32'hA5A5_0001;
  localparam logic [31:0] DEFF = 32'h5A5A_0002;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          waitreq = 1'b0;
  logic [31:0]   pin_arr [N];
  logic [31:0]   func_arr [N];
  logic [32*N-1:0] cfg_pin;
  logic [32*N-1:0] cfg_func;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          wr;
  logic [1:0]    addr;
  logic [31:0]   wdata;

  int total = 0;
  int bad = 0;
  int acc_writes = 0;

  // Reference model: owner (-1 when free), count of accepted writes in the
  // current ownership, whether the grant is being held, and the last owner.
  int          m_owner;
  int          m_acc;
  bit          m_hold;
  int          m_last;
  logic [31:0] m_pin;
  logic [31:0] m_func;

  typedef struct {
    logic [N-1:0] req;
    logic         wt;
    logic [N-1:0] gnt;
    logic         busy;
    logic         wr;
    logic [1:0]   addr;
    logic [31:0]  data;
  } vec_t;

  vec_t tbl [7];

  assign cfg_pin  = {pin_arr[3], pin_arr[2], pin_arr[1], pin_arr[0]};
  assign cfg_func = {func_arr[3], func_arr[2], func_arr[1], func_arr[0]};

  always #5 clk = ~clk;

  peridot_pfc_arbiter #(
    .NUM_REQ(N),
    .DEFAULT_PINREGS(DEFP),
    .DEFAULT_FUNCREGS(DEFF)
  ) dut (
    .csi_clk(clk),
    .rsi_reset_n(rst_n),
    .coe_req(req),
    .coe_gnt(gnt),
    .coe_cfg_pinsel(cfg_pin),
    .coe_cfg_funcsel(cfg_func),
    .coe_busy(busy),
    .avm_address(addr),
    .avm_write(wr),
    .avm_writedata(wdata),
    .avm_waitrequest(waitreq)
  );

  // Watchdog so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_acc   = 0;
    m_hold  = 1'b0;
    m_last  = N - 1;
    m_pin   = '0;
    m_func  = '0;
  endtask

  task automatic modelStep();
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_pin   = pin_arr[c];
          m_func  = func_arr[c];
          m_acc   = 0;
          m_hold  = 1'b0;
        end
      end
    end else if (m_hold) begin
      if (!req[m_owner]) m_hold = 1'b0;
    end else if (!waitreq) begin
      m_acc++;
      if (m_acc == 2 && req[m_owner]) begin
        m_hold = 1'b1;
      end else if (m_acc == 4) begin
        m_last  = m_owner;
        m_owner = -1;
        m_acc   = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic w);
    req     = r;
    waitreq = w;
    if (wr && !w) acc_writes++;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name);
    logic [N-1:0] eg;
    logic         ew;
    logic [31:0]  ed;
    eg = m_hold ? N'(1 << m_owner) : '0;
    ew = (m_owner >= 0) && !m_hold;
    case (m_acc)
      0:       ed = m_pin;
      1:       ed = m_func;
      2:       ed = DEFP;
      default: ed = DEFF;
    endcase
    checkVal({name, ".gnt"}, 32'(gnt), 32'(eg));
    checkVal({name, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    checkVal({name, ".write"}, 32'(wr), 32'(ew));
    if (ew) begin
      checkVal({name, ".addr"}, 32'(addr), (m_acc % 2 == 0) ? 32'd2 : 32'd3);
      checkVal({name, ".data"}, wdata, ed);
    end
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    req     = '0;
    waitreq = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int s = 0; s < 40 && m_owner >= 0; s++) begin
      applyStimulus('0, 1'b0);
      checkOutput(name);
    end
    checkVal({name, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          gc;
    int          stall;
    bit          started;
    bit          saw_gnt;
    logic [N-1:0] r;
    logic        w;
    int          order [$];
    int          exp_order [5];

    pin_arr[0] = 32'h1111_0000; func_arr[0] = 32'h1111_000F;
    pin_arr[1] = 32'h0000_0098; func_arr[1] = 32'h0000_000A;
    pin_arr[2] = 32'h3333_0000; func_arr[2] = 32'h3333_000F;
    pin_arr[3] = 32'h4444_0000; func_arr[3] = 32'h4444_000F;
    modelReset();

    // Reset state while reset is asserted
    #12;
    checkVal("rst.gnt", 32'(gnt), 32'd0);
    checkVal("rst.busy", 32'(busy), 32'd0);
    checkVal("rst.write", 32'(wr), 32'd0);
    checkVal("rst.addr", 32'(addr), 32'd0);
    checkVal("rst.data", wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single owner, no stalls: three cycles to grant, release writes defaults
    tbl[0] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'h0000_0098};
    tbl[1] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 32'h0000_000A};
    tbl[2] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[3] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[4] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, DEFP};
    tbl[5] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, DEFF};
    tbl[6] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].req, tbl[i].wt);
      checkVal($sformatf("tbl%0d.gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      checkVal($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      checkVal($sformatf("tbl%0d.write", i), 32'(wr), 32'(tbl[i].wr));
      if (tbl[i].wr) begin
        checkVal($sformatf("tbl%0d.addr", i), 32'(addr), 32'(tbl[i].addr));
        checkVal($sformatf("tbl%0d.data", i), wdata, tbl[i].data);
      end
      checkOutput($sformatf("tblm%0d", i));
    end

    // Round robin with all requesters active, each owner holds 5 grant cycles
    doReset();
    r  = '1;
    gc = 0;
    for (int s = 0; s < 300 && order.size() < 5; s++) begin
      if (m_owner < 0) begin
        r = '1;
      end else if (m_hold) begin
        gc++;
        if (gc >= 5) r[m_owner] = 1'b0;
      end else begin
        gc = 0;
      end
      applyStimulus(r, 1'b0);
      checkOutput("rr");
      if (gnt != '0 && m_hold && gc == 0) begin
        for (int b = 0; b < N; b++) if (gnt[b]) order.push_back(b);
      end
    end
    exp_order = '{0, 1, 2, 3, 0};
    checkVal("rr.count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      checkVal($sformatf("rr.order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    end
    drain("rr.drain");

    // Four stall cycles on every write; exactly four writes accepted
    doReset();
    acc_writes = 0;
    stall   = 0;
    gc      = 0;
    started = 1'b0;
    r       = 4'b0010;
    for (int s = 0; s < 80; s++) begin
      if (started && m_owner < 0) break;
      w = 1'b0;
      if (m_owner >= 0 && !m_hold) begin
        if (stall < 4) begin
          w = 1'b1;
          stall++;
        end else begin
          stall = 0;
        end
      end
      if (m_hold) begin
        gc++;
        if (gc >= 3) r = '0;
      end
      applyStimulus(r, w);
      checkOutput("wait");
      if (m_owner >= 0) started = 1'b1;
    end
    checkVal("wait.writes", 32'(acc_writes), 32'd4);
    checkVal("wait.idle", 32'(busy), 32'd0);

    // Request dropped during the pinsel write: no grant pulse, release follows
    saw_gnt = 1'b0;
    applyStimulus(4'b0100, 1'b0);
    checkOutput("drop");
    for (int s = 0; s < 10 && m_owner >= 0; s++) begin
      applyStimulus('0, 1'b0);
      checkOutput("drop");
      if (gnt != '0) saw_gnt = 1'b1;
    end
    checkVal("drop.nognt", 32'(saw_gnt), 32'd0);
    checkVal("drop.idle", 32'(busy), 32'd0);

    // Owner config changed mid-write: latched word still written
    pin_arr[0] = 32'h0000_1234;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("cfg");
    pin_arr[0] = 32'hFFFF_FFFF;
    applyStimulus(4'b0001, 1'b1);
    checkOutput("cfg");
    checkVal("cfg.latched", wdata, 32'h0000_1234);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput("cfg");
    end
    drain("cfg.drain");
    pin_arr[0] = 32'h1111_0000;

    // Asynchronous reset during a stalled funcsel write
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("rmid");
    waitreq = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("rmid.write", 32'(wr), 32'd0);
    checkVal("rmid.gnt", 32'(gnt), 32'd0);
    checkVal("rmid.busy", 32'(busy), 32'd0);
    modelReset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      applyStimulus(4'b1000, 1'b0);
      checkOutput("rmid.after");
    end
    checkVal("rmid.gnt3", 32'(gnt), 32'h8);
    drain("rmid.drain");

    // Random requests, stalls and config churn against the model
    for (int s = 0; s < 500; s++) begin
      r = req;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) pin_arr[$urandom_range(0, N-1)] = $urandom;
      if ($urandom_range(0, 3) == 0) func_arr[$urandom_range(0, N-1)] = $urandom;
      applyStimulus(r, w);
      checkOutput("rnd");
    end
    drain("rnd.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
